// File: rtl/pwm_fade_pkg.sv
// Purpose: shared types and defaults for the PWM fade scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_fade_pkg;

    localparam int NCH_DEF    = 8;
    localparam int W_DEF      = 28;
    localparam int STEP_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } fade_state_e;

    // Channel index width; a single channel still needs one index bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_fade_sched_if.sv
// Purpose: fade tick, config write channel and per-channel PWM-side signals.
// Latency: n/a (wiring only).
// Backpressure: config writes are qualified by cfg_ready.
interface pwm_fade_sched_if
    import pwm_fade_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int W      = W_DEF,
    parameter int STEP_W = STEP_W_DEF
);
    localparam int CW = ch_idx_w(NCH);

    logic              tick;
    logic              cfg_we;
    logic [CW-1:0]     cfg_ch;
    logic [W-1:0]      cfg_target;
    logic [STEP_W-1:0] cfg_step;
    logic              cfg_ready;
    logic [NCH-1:0]    period_end;
    logic [NCH*W-1:0]  decode_out;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;

    // Software / prescaler / PWM counter side
    modport master (
        output tick, cfg_we, cfg_ch, cfg_target, cfg_step, period_end,
        input  cfg_ready, decode_out, busy, done
    );

    // Scheduler side
    modport slave (
        input  tick, cfg_we, cfg_ch, cfg_target, cfg_step, period_end,
        output cfg_ready, decode_out, busy, done
    );
endinterface

// File: rtl/pwm_fade_step.sv
// Purpose: one ramp step of cur toward target, clamped so it never overshoots or wraps.
// Latency: combinational.
// Backpressure: none.
module pwm_fade_step #(
    parameter int W      = 28,
    parameter int STEP_W = 16
) (
    input  logic [W-1:0]      cur,
    input  logic [W-1:0]      target,
    input  logic [STEP_W-1:0] step,
    output logic [W-1:0]      next_cur,
    output logic              reached
);
    logic [W:0] step_x;
    logic [W:0] sum;
    logic [W:0] diff;

    // Move by step in W+1 bits; a zero step means jump straight to target.
    always_comb begin
        step_x   = {{(W+1-STEP_W){1'b0}}, step};
        sum      = {1'b0, cur} + step_x;
        diff     = {1'b0, cur} - step_x;
        next_cur = cur;
        if (cur < target) begin
            if ((step == '0) || (sum >= {1'b0, target})) next_cur = target;
            else                                          next_cur = sum[W-1:0];
        end else if (cur > target) begin
            // diff[W] set means cur - step went below zero
            if ((step == '0) || diff[W] || (diff[W-1:0] <= target)) next_cur = target;
            else                                                     next_cur = diff[W-1:0];
        end
        reached = (cur != target) && (next_cur == target);
    end
endmodule

// File: rtl/pwm_fade_sched.sv
// Purpose: time-shares one ramp unit across NCH PWM channels; optional PWM_FADE_SYNC_EN period-synced decode.
// Latency: tick in IDLE updates channel k's cur k+1 cycles later; decode_out follows one cycle after cur.
// Backpressure: cfg_ready drops while a write taken mid-scan is held; writes with cfg_ready=0 are dropped.
module pwm_fade_sched
    import pwm_fade_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int W      = W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input logic            CLK,
    input logic            RST_N,
    pwm_fade_sched_if.slave bus
);
    localparam int CW = ch_idx_w(NCH);

    fade_state_e       state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic              pend_q, pend_d;
    logic              hold_valid_q, hold_valid_d;
    logic [CW-1:0]     hold_ch_q, hold_ch_d;
    logic [W-1:0]      hold_target_q, hold_target_d;
    logic [STEP_W-1:0] hold_step_q, hold_step_d;

    logic [W-1:0]      cur_q [NCH];
    logic [W-1:0]      cur_d [NCH];
    logic [W-1:0]      target_q [NCH];
    logic [W-1:0]      target_d [NCH];
    logic [STEP_W-1:0] step_q [NCH];
    logic [STEP_W-1:0] step_d [NCH];
    logic [W-1:0]      decode_q [NCH];
    logic [W-1:0]      decode_d [NCH];
    logic [NCH-1:0]    busy_q, busy_d;
    logic [NCH-1:0]    done_q, done_d;

    logic              scan_en;
    logic              cfg_accept;
    logic              wr_en;
    logic [CW-1:0]     wr_ch;
    logic [W-1:0]      wr_target;
    logic [STEP_W-1:0] wr_step;
    logic [W-1:0]      step_next;
    logic              step_reached;

    // Single shared ramp unit, fed by the channel currently being visited
    pwm_fade_step #(.W(W), .STEP_W(STEP_W)) u_step (
        .cur      (cur_q[idx_q]),
        .target   (target_q[idx_q]),
        .step     (step_q[idx_q]),
        .next_cur (step_next),
        .reached  (step_reached)
    );

    // Scan sequencer: IDLE -> SCAN (one channel per cycle) -> DRAIN; one tick can queue behind a scan
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        scan_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.tick || pend_q) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            SCAN: begin
                scan_en = 1'b1;
                if (bus.tick) pend_d = 1'b1;
                if (idx_q == CW'(NCH-1)) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                if (bus.tick) pend_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Channel state: config writes outside SCAN (held write first), ramp update for the visited channel
    always_comb begin
        cur_d         = cur_q;
        target_d      = target_q;
        step_d        = step_q;
        done_d        = '0;
        busy_d        = '0;
        hold_valid_d  = hold_valid_q;
        hold_ch_d     = hold_ch_q;
        hold_target_d = hold_target_q;
        hold_step_d   = hold_step_q;

        cfg_accept = bus.cfg_we && !hold_valid_q;
        // A write can only land when no scan visit is touching the channel array
        wr_en      = (state_q != SCAN) && (hold_valid_q || cfg_accept);
        wr_ch      = hold_valid_q ? hold_ch_q     : bus.cfg_ch;
        wr_target  = hold_valid_q ? hold_target_q : bus.cfg_target;
        wr_step    = hold_valid_q ? hold_step_q   : bus.cfg_step;

        if ((state_q == SCAN) && cfg_accept) begin
            hold_valid_d  = 1'b1;
            hold_ch_d     = bus.cfg_ch;
            hold_target_d = bus.cfg_target;
            hold_step_d   = bus.cfg_step;
        end
        if (wr_en) hold_valid_d = 1'b0;

        for (int i = 0; i < NCH; i++) begin
            if (wr_en && (wr_ch == CW'(i))) begin
                target_d[i] = wr_target;
                step_d[i]   = wr_step;
                if (wr_step == '0) cur_d[i] = wr_target;
            end
            if (scan_en && (idx_q == CW'(i))) begin
                cur_d[i]  = step_next;
                done_d[i] = step_reached;
            end
            busy_d[i] = (cur_d[i] != target_d[i]);
        end
    end

    // Decode shadow: either tracks cur directly or reloads only at the channel's period boundary
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
`ifdef PWM_FADE_SYNC_EN
            decode_d[i] = bus.period_end[i] ? cur_q[i] : decode_q[i];
`else
            decode_d[i] = cur_q[i];
`endif
        end
    end

`ifndef PWM_FADE_SYNC_EN
    logic unused_period_end;
    assign unused_period_end = ^bus.period_end;
`endif

    // State registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            pend_q        <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_ch_q     <= '0;
            hold_target_q <= '0;
            hold_step_q   <= '0;
            busy_q        <= '0;
            done_q        <= '0;
            for (int i = 0; i < NCH; i++) begin
                cur_q[i]    <= '0;
                target_q[i] <= '0;
                step_q[i]   <= '0;
                decode_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pend_q        <= pend_d;
            hold_valid_q  <= hold_valid_d;
            hold_ch_q     <= hold_ch_d;
            hold_target_q <= hold_target_d;
            hold_step_q   <= hold_step_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cur_q         <= cur_d;
            target_q      <= target_d;
            step_q        <= step_d;
            decode_q      <= decode_d;
        end
    end

    // Output packing
    always_comb begin
        bus.cfg_ready = !hold_valid_q;
        bus.busy      = busy_q;
        bus.done      = done_q;
        for (int i = 0; i < NCH; i++) begin
            bus.decode_out[i*W +: W] = decode_q[i];
        end
    end
endmodule

// File: tb/tb_pwm_fade_sched.sv
// Purpose: scoreboard bench for pwm_fade_sched; expected decode changes and done pulses are queued by stimulus.
// Latency: monitor samples on the falling edge; direct checks sample 1 time unit after the rising edge.
// Backpressure: exercises cfg_ready hold/drop during a scan.
module tb_pwm_fade_sched;
    import pwm_fade_pkg::*;

    localparam int NCH    = 8;
    localparam int W      = 28;
    localparam int STEP_W = 16;
    localparam int CW     = ch_idx_w(NCH);

    typedef struct {
        int          ch;
        logic [31:0] val;
    } dec_exp_t;

    logic CLK = 1'b0;
    logic RST_N;

    int n_cmp = 0;
    int n_err = 0;

    dec_exp_t dec_q[$];
    int       done_q[$];

    pwm_fade_sched_if #(.NCH(NCH), .W(W), .STEP_W(STEP_W)) bus ();

    pwm_fade_sched #(.NCH(NCH), .W(W), .STEP_W(STEP_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [31:0] dec(input int ch);
        return 32'(bus.decode_out[ch*W +: W]);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic exp_dec(input int ch, input logic [31:0] v);
        dec_exp_t e;
        e.ch  = ch;
        e.val = v;
        dec_q.push_back(e);
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input logic [31:0] tgt, input logic [31:0] stp);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = CW'(ch);
        bus.cfg_target = W'(tgt);
        bus.cfg_step   = STEP_W'(stp);
        cyc(1);
        bus.cfg_we     = 1'b0;
    endtask

    // Monitor: every decode change and every done pulse must match the head of its queue
    initial begin
        logic [31:0] prev [NCH];
        logic [31:0] now_v;
        dec_exp_t    e;
        int          ech;
        for (int c = 0; c < NCH; c++) prev[c] = '0;
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1) begin
                for (int c = 0; c < NCH; c++) begin
                    now_v = dec(c);
                    if (now_v !== prev[c]) begin
                        if (dec_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL dec_unexpected ch%0d: got %0d, expected no change from %0d", c, now_v, prev[c]);
                        end else begin
                            e = dec_q.pop_front();
                            chk($sformatf("dec_ch ch%0d", c), 32'(c), 32'(e.ch));
                            chk($sformatf("dec_val ch%0d", c), now_v, e.val);
                        end
                        prev[c] = now_v;
                    end
                    if (bus.done[c] === 1'b1) begin
                        if (done_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL done_unexpected ch%0d: got pulse, expected none", c);
                        end else begin
                            ech = done_q.pop_front();
                            chk("done_ch", 32'(c), 32'(ech));
                            chk($sformatf("busy_at_done ch%0d", c), 32'(bus.busy[c]), 32'd0);
                        end
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        RST_N          = 1'b0;
        bus.tick       = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_target = '0;
        bus.cfg_step   = '0;
        bus.period_end = '1;
        cyc(3);
        RST_N = 1'b1;

        // Reset state, immediately and after 100 idle cycles
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        cyc(100);
        for (int c = 0; c < NCH; c++) chk($sformatf("idle_decode ch%0d", c), dec(c), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_cfg_ready", 32'(bus.cfg_ready), 32'd1);

        // Ch2 ramps up 0 -> 300 -> 600 -> 900 -> 1000
        cfg_write(2, 1000, 300);
        chk("ch2_busy_after_write", 32'(bus.busy[2]), 32'd1);
        exp_dec(2, 300);
        do_tick();
        cyc(3);
        chk("ch2_latency_early", dec(2), 32'd0);
        cyc(1);
        chk("ch2_latency_on_time", dec(2), 32'd300);
        cyc(8);
        exp_dec(2, 600);
        do_tick();
        cyc(12);
        exp_dec(2, 900);
        do_tick();
        cyc(12);
        exp_dec(2, 1000);
        done_q.push_back(2);
        do_tick();
        cyc(12);
        chk("ch2_busy_end", 32'(bus.busy[2]), 32'd0);

        // Ch5 ramps down 1000 -> 600 -> 200 -> 50 without underflow
        exp_dec(5, 1000);
        cfg_write(5, 1000, 0);
        cyc(2);
        cfg_write(5, 50, 400);
        exp_dec(5, 600);
        do_tick();
        cyc(12);
        exp_dec(5, 200);
        do_tick();
        cyc(12);
        exp_dec(5, 50);
        done_q.push_back(5);
        do_tick();
        cyc(12);
        // Zero step: jump with no tick
        exp_dec(5, 1000);
        cfg_write(5, 1000, 0);
        cyc(2);
        exp_dec(5, 50);
        cfg_write(5, 50, 0);
        cyc(1);
        chk("ch5_step0_jump", dec(5), 32'd50);
        chk("ch5_step0_busy", 32'(bus.busy[5]), 32'd0);
        cyc(4);

        // Write while the scan is at ch3 is held until DRAIN; a second write is dropped
        exp_dec(1, 123);
        do_tick();
        cyc(3);
        cfg_write(1, 123, 0);
        chk("hold_ready_low", 32'(bus.cfg_ready), 32'd0);
        cfg_write(4, 999, 0);
        chk("hold_ready_low2", 32'(bus.cfg_ready), 32'd0);
        cyc(3);
        chk("hold_ready_in_drain", 32'(bus.cfg_ready), 32'd0);
        chk("hold_not_early", dec(1), 32'd0);
        cyc(1);
        chk("hold_ready_back", 32'(bus.cfg_ready), 32'd1);
        cyc(1);
        chk("hold_landed", dec(1), 32'd123);
        chk("dropped_write_ch4", dec(4), 32'd0);
        cyc(6);

        // Tick and write in the same IDLE cycle: the scan sees the new ch6 values
        exp_dec(6, 5);
        done_q.push_back(6);
        bus.tick = 1'b1;
        cfg_write(6, 5, 5);
        bus.tick = 1'b0;
        cyc(12);

        // Three ticks: one starts a scan, one queues, one is dropped -> two steps on ch3
        cfg_write(3, 10, 4);
        exp_dec(3, 4);
        exp_dec(3, 8);
        do_tick();
        do_tick();
        cyc(1);
        do_tick();
        cyc(25);
        chk("ch3_two_scans", dec(3), 32'd8);
        exp_dec(3, 10);
        done_q.push_back(3);
        do_tick();
        cyc(12);

        // Ch7 near full scale: cur + step exceeds W bits and must clamp, not wrap
        exp_dec(7, 32'h0FFF_8000);
        cfg_write(7, 32'h0FFF_8000, 0);
        cyc(2);
        cfg_write(7, 32'h0FFF_FFFF, 32'h0000_FFFF);
        exp_dec(7, 32'h0FFF_FFFF);
        done_q.push_back(7);
        do_tick();
        cyc(12);

        // Ch0 decode vs period boundary
        bus.period_end[0] = 1'b0;
`ifdef PWM_FADE_SYNC_EN
        exp_dec(0, 60);
`else
        exp_dec(0, 40);
        exp_dec(0, 60);
`endif
        cfg_write(0, 40, 0);
        chk("ch0_before", dec(0), 32'd0);
        cyc(1);
`ifdef PWM_FADE_SYNC_EN
        chk("ch0_follow", dec(0), 32'd0);
`else
        chk("ch0_follow", dec(0), 32'd40);
`endif
        cfg_write(0, 60, 0);
        cyc(3);
`ifdef PWM_FADE_SYNC_EN
        chk("ch0_hold", dec(0), 32'd0);
`else
        chk("ch0_hold", dec(0), 32'd60);
`endif
        bus.period_end[0] = 1'b1;
        cyc(1);
        chk("ch0_after_period_end", dec(0), 32'd60);
        cyc(5);

        chk("dec_queue_empty", 32'(dec_q.size()), 32'd0);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_fade_sched.md
Name: pwm_fade_sched

Overview:
- Scheduler that time-shares one ramp (fade) engine across NCH PWM channels.
- Ramps each channel's active duty value toward a software target by a per-channel step, once per fade tick.
- Drives the Decode inputs of the PWM counters and sits between the Nios PIO registers and those counters.
- Updates each channel's duty only at that channel's PWM period boundary, so a pulse is never cut short or stretched.

Parameters:
- NCH, 8, number of PWM channels served.
- W, 28, duty/decode width; matches the PWM counter width.
- STEP_W, 16, width of the per-channel step size.

Ports:
- CLK  in  1  system clock; the only clock.
- RST_N  in  1  reset, asynchronous assert, active-low.
- tick  in  1  single-cycle fade tick from the prescaler; starts one scan of all channels.
- cfg_we  in  1  config write strobe; accepted only when cfg_ready=1.
- cfg_ch  in  $clog2(NCH)  channel index for the write.
- cfg_target  in  W  target duty.
- cfg_step  in  STEP_W  ramp step; 0 = jump immediately.
- cfg_ready  out  1  config write can be accepted.
- period_end  in  NCH  per-channel pulse, high in the cycle that PWM counter clears.
- decode_out  out  NCH*W  per-channel duty to the PWM comparators; channel i at bits [i*W +: W].
- busy  out  NCH  channel i has cur != target.
- done  out  NCH  single-cycle pulse when channel i reaches its target during a scan.

Behaviour:
- Per-channel state: cur[W], target[W], step[STEP_W].
- Reset values: all cur/target/step/decode_out = 0; busy = 0; done = 0; cfg_ready = 1; FSM = IDLE; pend_tick = 0; hold_valid = 0.

FSM:
- IDLE: if tick or pend_tick, go to SCAN with idx = 0 and clear pend_tick.
- SCAN: processes channel idx in one cycle, then increments idx.
  - After idx = NCH-1, go to DRAIN.
- DRAIN: one cycle. Apply the held config write if hold_valid, then go to IDLE.
- A tick received in SCAN or DRAIN sets pend_tick (depth 1; further ticks are dropped).
- Scan latency: a tick with FSM in IDLE updates channel k in cycle k+1 after the tick.

Per-channel step, in the SCAN cycle for channel idx:
- If cur < target: cur <= min(cur + step, target).
- If cur > target: cur <= max(cur - step, target).
- If cur == target: no change.
- Arithmetic is done in W+1 bits; step is zero-extended. No wrap and no overshoot.
- If step == 0 and cur != target: cur <= target in that visit.
- done[idx] pulses in the cycle after the visit in which cur becomes equal to target. No pulse if cur already equalled target.

Config writes:
- In IDLE: target and step are written next cycle.
  - If cfg_step == 0, cur is also set to cfg_target in the same cycle.
- In SCAN: the write is captured into a one-entry hold register and cfg_ready drops to 0 until DRAIN applies it.
  - A write while cfg_ready = 0 is ignored.
- A tick and cfg_we in the same IDLE cycle: the write is applied and the scan starts. The scan sees the new values from the channel 0 visit onward.

Other rules:
- busy[i] = (cur[i] != target[i]), registered.
- Reset mid-scan: all state returns to reset values; the pending tick and held write are lost.

Optional Feature:
- Macro: PWM_FADE_SYNC_EN.
- Defined: decode_out[i] is a shadow register loaded from cur[i] only when period_end[i] = 1. If cur changes twice within one period, only the latest value is loaded.
- Undefined: decode_out[i] = cur[i] registered; period_end is unused.

Decomposition:
- Package pwm_fade_pkg:
  - FSM state enum (IDLE, SCAN, DRAIN).
  - Default NCH/W/STEP_W constants.
  - Channel index width function.
- Sub-module pwm_fade_step: combinational step/clamp unit.
  - Inputs cur, target, step; outputs next_cur and reached.
  - One instance, shared across channels by the scheduler mux.

Test Plan:
- Reset release, no stimulus -> all decode_out = 0, busy = 0, cfg_ready = 1, state IDLE for 100 cycles.
- Ch2: target = 1000, step = 300, four ticks -> cur = 300, 600, 900, 1000; done[2] pulses once, after the 4th tick; busy[2] falls with it.
- Ch5: cur = 1000, target = 50, step = 400 -> 600, 200, 50; no underflow. With step = 0 the write sets cur = 50 the next cycle, with no tick.
- cfg_we while the scan is at ch3 -> cfg_ready = 0 until DRAIN, the write lands in DRAIN, and a second write during cfg_ready = 0 is dropped.
- Two ticks during one scan -> exactly one extra scan follows immediately; the third tick is dropped; per-channel step count = 2.
- With PWM_FADE_SYNC_EN: ch0 cur changes mid-period -> decode_out[0] holds its old value until the period_end[0] cycle, then takes the latest cur. Without the macro, decode_out[0] follows cur one cycle later.
